// File: rtl/apb_pkg.sv
// Shared types and constants for the processor-to-APB master bridge.
// Holds the master FSM state encoding and the fixed select/error values.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [7:0] RDATA_ERR = 8'hFF;

endpackage

// File: rtl/apb_resp_mux.sv
// Response mux: picks ready/rdata of the slave addressed by sel.
// Ports: sel, ready1/rdata1, ready2/rdata2 in; sel_valid, ready, rdata out.
module apb_resp_mux #(
    parameter logic [1:0] ID1 = 2'd1,
    parameter logic [1:0] ID2 = 2'd2
) (
    input  logic [1:0] sel,
    input  logic       ready1,
    input  logic [7:0] rdata1,
    input  logic       ready2,
    input  logic [7:0] rdata2,
    output logic       sel_valid,
    output logic       ready,
    output logic [7:0] rdata
);

    always_comb begin
        sel_valid = (sel == ID1) || (sel == ID2);
        // Anything not ID1 routes to slave 2; unmapped selects are
        // rejected upstream via sel_valid before this path matters.
        ready     = (sel == ID1) ? ready1 : ready2;
        rdata     = (sel == ID1) ? rdata1 : rdata2;
    end

endmodule

// File: rtl/apb_proc_master.sv
// APB master: turns one processor request into a SETUP/ACCESS transfer.
// Ports: clk, reset; proc_* request/result side; apb_* bus side.
module apb_proc_master
    import apb_pkg::*;
#(
    parameter logic [1:0]  ID1     = 2'd1,
    parameter logic [1:0]  ID2     = 2'd2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       proc_start,
    input  logic       proc_write,
    input  logic [1:0] proc_sel,
    input  logic [7:0] proc_addr,
    input  logic [7:0] proc_wdata,
    output logic [7:0] proc_rdata,
    output logic       proc_stable,
    output logic       proc_err,
    output logic [1:0] apb_sel,
    output logic       apb_enable,
    output logic       apb_write,
    output logic [7:0] apb_addr,
    output logic [7:0] apb_wdata,
    input  logic       apb_ready1,
    input  logic [7:0] apb_rdata1,
    input  logic       apb_ready2,
    input  logic [7:0] apb_rdata2
);

    // Counter value on the last allowed ACCESS cycle without ready.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    apb_state_t state, state_n;

    logic [7:0] tcnt, tcnt_n;
    logic [7:0] rdata_n;
    logic       stable_n;
    logic       err_n;
    logic [1:0] sel_n;
    logic       enable_n;
    logic       write_n;
    logic [7:0] addr_n;
    logic [7:0] wdata_n;

    logic [1:0] mux_sel;
    logic       sel_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;

    // In IDLE the incoming sel is validated; afterwards the latched one
    // steers the response path.
    assign mux_sel = (state == IDLE) ? proc_sel : apb_sel;

    apb_resp_mux #(
        .ID1 (ID1),
        .ID2 (ID2)
    ) u_resp_mux (
        .sel       (mux_sel),
        .ready1    (apb_ready1),
        .rdata1    (apb_rdata1),
        .ready2    (apb_ready2),
        .rdata2    (apb_rdata2),
        .sel_valid (sel_valid),
        .ready     (rsp_ready),
        .rdata     (rsp_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= 8'h00;
            proc_rdata  <= 8'h00;
            proc_stable <= 1'b1;
            proc_err    <= 1'b0;
            apb_sel     <= SEL_NONE;
            apb_enable  <= 1'b0;
            apb_write   <= 1'b0;
            apb_addr    <= 8'h00;
            apb_wdata   <= 8'h00;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            proc_rdata  <= rdata_n;
            proc_stable <= stable_n;
            proc_err    <= err_n;
            apb_sel     <= sel_n;
            apb_enable  <= enable_n;
            apb_write   <= write_n;
            apb_addr    <= addr_n;
            apb_wdata   <= wdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        rdata_n  = proc_rdata;
        stable_n = proc_stable;
        err_n    = proc_err;
        sel_n    = apb_sel;
        enable_n = apb_enable;
        write_n  = apb_write;
        addr_n   = apb_addr;
        wdata_n  = apb_wdata;

        case (state)
            IDLE: begin
                if (proc_start) begin
                    if (sel_valid) begin
                        sel_n    = proc_sel;
                        write_n  = proc_write;
                        addr_n   = proc_addr;
                        wdata_n  = proc_wdata;
                        err_n    = 1'b0;
                        stable_n = 1'b0;
                        tcnt_n   = 8'h00;
                        state_n  = SETUP;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SETUP: begin
                enable_n = 1'b1;
                state_n  = ACCESS;
            end

            ACCESS: begin
                if (rsp_ready) begin
                    if (!apb_write) begin
                        rdata_n = rsp_rdata;
                    end
                    state_n  = IDLE;
                    sel_n    = SEL_NONE;
                    enable_n = 1'b0;
                    stable_n = 1'b1;
                end else if (tcnt == TCNT_LAST) begin
                    // This wait cycle brings the count to TIMEOUT: abort.
                    if (!apb_write) begin
                        rdata_n = RDATA_ERR;
                    end
                    tcnt_n   = tcnt + 8'd1;
                    err_n    = 1'b1;
                    state_n  = IDLE;
                    sel_n    = SEL_NONE;
                    enable_n = 1'b0;
                    stable_n = 1'b1;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/apb_proc_master.md
Name: apb_proc_master

Overview:
Bridges the processor-side request bus onto the shared APB bus feeding the two APB slave/memory pairs. It captures one processor request on a start pulse and runs a standard SETUP/ACCESS APB transfer to the slave whose ID matches sel. It muxes that slave's ready/rdata back to the processor and reports completion via stable, or error via err on unmapped sel or timeout. It is the master stage directly upstream of the APB slaves.

Parameters:
ID1, 2'd1, slave ID of APB slave 1; must match that slave's id input.
ID2, 2'd2, slave ID of APB slave 2; must differ from ID1 and from 2'd0.
TIMEOUT, 16, max ACCESS cycles waiting for ready before abort; range 1..255.

Ports:
(One clock, clk; reset is synchronous and active-high, sampled on posedge clk.)
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
proc_start  in  1  request strobe, sampled only in IDLE.
proc_write  in  1  1 = write, 0 = read.
proc_sel  in  2  target slave ID.
proc_addr  in  8  target address.
proc_wdata  in  8  write data.
proc_rdata  out  8  read data of last completed read.
proc_stable  out  1  1 = idle and result valid; 0 = transfer in progress.
proc_err  out  1  1 = last request failed (unmapped sel or timeout).
apb_sel  out  2  slave select; 2'd0 = no slave.
apb_enable  out  1  APB enable (ACCESS phase).
apb_write  out  1  APB direction.
apb_addr  out  8  APB address.
apb_wdata  out  8  APB write data.
apb_ready1  in  1  ready from slave ID1.
apb_rdata1  in  8  rdata from slave ID1.
apb_ready2  in  1  ready from slave ID2.
apb_rdata2  in  8  rdata from slave ID2.

Behaviour:
- Reset values: state IDLE; proc_rdata 8'h00; proc_stable 1; proc_err 0; apb_sel 2'd0; apb_enable 0; apb_write 0; apb_addr 8'h00; apb_wdata 8'h00; timeout counter 0.
- Reset during any state forces IDLE next cycle. No partial transfer is completed, and proc_rdata and proc_err take their reset values.
- IDLE:
  - proc_start=1 with proc_sel in {ID1, ID2}: register write/sel/addr/wdata onto the apb_* outputs, clear proc_err, drop proc_stable to 0, go to SETUP.
  - proc_start=1 with unmapped sel (including 2'd0): no APB activity. Next cycle proc_err=1, proc_stable stays 1, state stays IDLE, proc_rdata unchanged.
- SETUP (exactly 1 cycle): apb_sel=target, apb_enable=0. Go to ACCESS.
- ACCESS:
  - apb_enable=1. Selected ready = apb_ready1 if sel==ID1, otherwise apb_ready2. The non-selected slave's ready and rdata are ignored.
  - On selected ready=1: if read, capture the selected rdata into proc_rdata. Go to IDLE. In that IDLE cycle apb_sel=0, apb_enable=0, proc_stable=1.
  - Timeout counter increments on each ACCESS cycle with ready=0. If the counter reaches TIMEOUT with ready still 0: abort to IDLE, proc_err=1, proc_stable=1, proc_rdata=8'hFF on reads (unchanged on writes).
- apb_addr, apb_wdata and apb_write are held constant from SETUP through the last ACCESS cycle. They retain their values in IDLE.
- proc_start is ignored while proc_stable=0; there is no queueing.
- Latency: start sampled at edge N → SETUP in cycle N+1, ACCESS in N+2. With zero wait states, proc_stable=1 and proc_rdata valid from edge N+3. Each wait state adds 1 cycle.
- Back-to-back: a new proc_start may be sampled in the first IDLE cycle after completion (minimum 3-cycle transfer period).

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  - localparam SEL_NONE = 2'd0;
  - localparam RDATA_ERR = 8'hFF.
- One sub-module: apb_resp_mux. Combinational; selects ready/rdata from sel, ID1 and ID2; outputs sel_valid, ready and rdata.
- FSM, request registers and timeout counter stay in apb_proc_master.

Test Plan:
- Read, zero wait: reset, then start (write=0, sel=ID1, addr=8'h10); slave1 ready=1 in first ACCESS with rdata1=8'hA5 → apb_sel=1 with enable 0 at N+1 and 1 at N+2; proc_rdata=8'hA5, stable=1, err=0 at N+3.
- Write, 2 wait states: start (write=1, sel=ID2, addr=8'h22, wdata=8'h5C); ready2 asserted on 3rd ACCESS cycle → apb_addr/apb_wdata stable throughout; stable returns at N+5; proc_rdata unchanged.
- Unmapped sel: start with sel=2'd3 → apb_sel remains 0, apb_enable never 1; err=1, stable=1 next cycle.
- Timeout: read to ID1 with ready1 held 0 → exactly TIMEOUT=16 ACCESS cycles, then IDLE; err=1, proc_rdata=8'hFF, apb_enable=0.
- Mux isolation and busy ignore:
  - Read to ID2 while ready1=1 and rdata1=8'h11 → ready1 is ignored, and the transfer completes only on ready2 with rdata2=8'h77 captured.
  - A proc_start pulsed during ACCESS → ignored.
- Reset mid-transfer: assert reset during ACCESS → next cycle all outputs at reset values; then a fresh read completes normally.
